rf_port_arbiter: RTL and testbench
==================================

RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; all state SHALL update on posedge clk.
REQ-002 Parameter LOCK_MAX, default 16, SHALL be the maximum number of consecutive cycles a lock may be held before forced release.
REQ-003 clk  in  1  system clock, shared with regfile.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 reqN_valid  in  1  requester N (N=0 core, N=1 debug) has a request.
REQ-006 reqN_ready  out  1  request accepted this cycle.
REQ-007 reqN_we  in  1  1=write, 0=read.
REQ-008 reqN_addr  in  5  register index.
REQ-009 reqN_wdata  in  32  write data.
REQ-010 reqN_lock  in  1  hold grant after this transfer.
REQ-011 rspN_valid  out  1  read data for requester N is on rsp_rdata.
REQ-012 rsp_rdata  out  32  read data, equal to rf_RD1.
REQ-013 rf_A1, rf_A3  out  5  regfile read/write addresses.
REQ-014 rf_WD3  out  32  regfile write data.
REQ-015 rf_WE  out  1  regfile write enable.
REQ-016 rf_RD1  in  32  regfile registered read data (1-cycle latency).

Function
REQ-017 A transfer SHALL occur in a cycle where reqN_valid && reqN_ready; at most one requester SHALL be ready per cycle.
REQ-018 reqN_ready SHALL be combinational from valid, state and priority; it SHALL NOT depend on the requester's ready.
REQ-019 The FSM SHALL have states ARB and LOCKED, plus registers owner (1 bit), prio (1 bit) and lock_cnt (clog2(LOCK_MAX+1) bits).
REQ-020 In ARB with one valid requester, that requester SHALL be ready.
REQ-021 In ARB with both requesters valid, requester prio SHALL be ready.
REQ-022 After any transfer by requester N, prio SHALL become 1-N.
REQ-023 In LOCKED, only owner SHALL be ready, regardless of the other requester's valid.
REQ-024 ARB->LOCKED SHALL occur on a transfer with reqN_lock=1, with owner=N and lock_cnt=0.
REQ-025 LOCKED->ARB SHALL occur on an owner transfer with lock=0.
REQ-026 LOCKED->ARB SHALL also occur when lock_cnt reaches LOCK_MAX-1 (forced release); the final transfer in that cycle is still accepted.
REQ-027 lock_cnt SHALL increment every cycle in LOCKED, whether or not a transfer occurs.
REQ-028 On a write transfer, the block SHALL drive rf_WE=1, rf_A3=addr and rf_WD3=wdata in the same cycle.
REQ-029 Without a write transfer, rf_WE SHALL be 0, and rf_A3 and rf_WD3 SHALL be 0.
REQ-030 On a read transfer, rf_A1 SHALL be addr; otherwise rf_A1 SHALL be 0.
REQ-031 rspN_valid SHALL assert exactly one cycle after a read transfer by N, for one cycle; rsp_rdata SHALL equal rf_RD1.
REQ-032 Read latency SHALL be 1 cycle from transfer to rspN_valid; back-to-back reads SHALL sustain 1 read per cycle.
REQ-033 Responses SHALL have no backpressure; requesters SHALL always accept them.
REQ-034 A write to X in cycle k followed by a read of X in cycle k+1 SHALL return the new value; no bypass is required because only one transfer occurs per cycle.
REQ-035 A read of address 0 SHALL return 0, and a write to address 0 SHALL be issued to the regfile, which ignores it.

Reset
REQ-036 While rst=1, the block SHALL force state=ARB, prio=0, owner=0, lock_cnt=0 and rspN_valid=0.
REQ-037 While rst=1, reqN_ready, rf_WE, rf_A1, rf_A3 and rf_WD3 SHALL be 0 combinationally.
REQ-038 rst asserted mid-lock or with a read pending SHALL drop the lock and the pending response, and SHALL NOT emit rspN_valid on the following cycle.

Verification
REQ-039 Both valid, both reads (addr 3 and 4), after reset -> req0 granted in cycle 1, rsp0_valid in cycle 2; req1 granted in cycle 2, rsp1_valid in cycle 3.
REQ-040 req0 writes 0xDEADBEEF to x5 in cycle k, then req1 reads x5 in cycle k+1 -> rsp1_valid in cycle k+2 with rsp_rdata=0xDEADBEEF.
REQ-041 req1 transfers with lock=1 while req0 is continuously valid, and req1 stays valid with lock=1 -> req0_ready stays 0 for 16 cycles; forced release follows, then req0 is granted.
REQ-042 req1 lock burst of 3 writes, last with lock=0 -> state returns to ARB, and req0 is granted on the next cycle.
REQ-043 Read of x0 -> rsp_rdata=0. Write to x0 -> rf_WE=1 and a later read of x0 still returns 0.
REQ-044 rst asserted in the cycle after a read transfer -> no rspN_valid, and all outputs are 0 while rst=1.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// ---------------------------------------------------------------------------
// rf_port_arbiter
//
// Shares a single register-file port pair (one registered read port, one
// write port) between two requesters: requester 0 (core) and requester 1
// (debug). One transfer is accepted per cycle. Plain arbitration alternates
// priority after every transfer. A requester may lock the port for a burst,
// and the lock is released by force after LOCK_MAX cycles.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid / reqN_ready  request handshake, N = 0 (core), 1 (debug)
//   reqN_we                  1 = write, 0 = read
//   reqN_addr                register index
//   reqN_wdata               write data
//   reqN_lock                keep the grant after this transfer
//   rspN_valid               read data for requester N is on rsp_rdata
//   rsp_rdata                read data (regfile rf_RD1)
//   rf_A1                    regfile read address
//   rf_A3, rf_WD3, rf_WE     regfile write address, data, enable
//   rf_RD1                   regfile read data, one cycle after rf_A1
// ---------------------------------------------------------------------------
module rf_port_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req0_lock,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic        req1_lock,

  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_rdata,

  output logic [4:0]  rf_A1,
  output logic [4:0]  rf_A3,
  output logic [31:0] rf_WD3,
  output logic        rf_WE,
  input  logic [31:0] rf_RD1
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  // Value of lock_cnt in the last cycle a lock may be held.
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t        state;
  logic          owner;     // lock holder, meaningful in LOCKED only
  logic          prio;      // requester that wins a tie in ARB
  logic [CW-1:0] lock_cnt;  // cycles spent in LOCKED so far
  logic [1:0]    rsp_pend;  // read accepted last cycle, per requester

  logic        xfer0;
  logic        xfer1;
  logic        xfer;
  logic        sel_we;
  logic [4:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_lock;

  // -------------------------------------------------------------------------
  // Grant. Ready never looks at the other side's ready, only at valids,
  // state and priority, so at most one requester is ready per cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      unique case (state)
        ARB: begin
          if (req0_valid && (!req1_valid || !prio)) req0_ready = 1'b1;
          else if (req1_valid)                      req1_ready = 1'b1;
        end
        LOCKED: begin
          req0_ready = req0_valid && !owner;
          req1_ready = req1_valid &&  owner;
        end
        default: ;
      endcase
    end
  end

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;
  assign xfer  = xfer0 || xfer1;

  // Winning request fields; only meaningful while xfer is high.
  assign sel_we    = xfer1 ? req1_we    : req0_we;
  assign sel_addr  = xfer1 ? req1_addr  : req0_addr;
  assign sel_wdata = xfer1 ? req1_wdata : req0_wdata;
  assign sel_lock  = xfer1 ? req1_lock  : req0_lock;

  // -------------------------------------------------------------------------
  // Regfile drive. Idle address/data are held at zero so the regfile sees
  // clean values when nothing is transferred. Writes to x0 go through; the
  // regfile ignores them.
  // -------------------------------------------------------------------------
  assign rf_WE  = xfer && sel_we;
  assign rf_A3  = rf_WE ? sel_addr  : 5'd0;
  assign rf_WD3 = rf_WE ? sel_wdata : 32'd0;
  assign rf_A1  = (xfer && !sel_we) ? sel_addr : 5'd0;

  // Responses are masked during reset so a read accepted just before reset
  // never shows up, even in the first reset cycle.
  assign rsp0_valid = rsp_pend[0] && !rst;
  assign rsp1_valid = rsp_pend[1] && !rst;
  assign rsp_rdata  = rst ? 32'd0 : rf_RD1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= ARB;
      owner    <= 1'b0;
      prio     <= 1'b0;
      lock_cnt <= '0;
      rsp_pend <= 2'b00;
    end else begin
      rsp_pend <= {xfer1 && !req1_we, xfer0 && !req0_we};

      // Loser of this transfer wins the next tie.
      if (xfer) prio <= ~xfer1;

      unique case (state)
        ARB: begin
          if (xfer && sel_lock) begin
            state    <= LOCKED;
            owner    <= xfer1;
            lock_cnt <= '0;
          end
        end
        LOCKED: begin
          // Forced release takes effect after the last allowed cycle; an
          // owner transfer in that cycle is still accepted above.
          if (lock_cnt == CNT_LAST || (xfer && !sel_lock)) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_port_arbiter
//
// Bench for rf_port_arbiter. Contains a small registered regfile attached to
// the rf_* ports, a directed vector table, hand-written lock sequences and a
// random phase compared against a cycle-level reference model of the
// arbitration rules.
// ---------------------------------------------------------------------------
module tb_rf_port_arbiter;

  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [4:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [4:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rf_A1, rf_A3;
  logic [31:0] rf_WD3;
  logic        rf_WE;
  logic [31:0] rf_RD1 = 32'd0;

  rf_port_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_lock  (req0_lock),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_lock  (req1_lock),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_rdata  (rsp_rdata),
    .rf_A1      (rf_A1),
    .rf_A3      (rf_A3),
    .rf_WD3     (rf_WD3),
    .rf_WE      (rf_WE),
    .rf_RD1     (rf_RD1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'd0 : (32'hA000_0000 | 32'(i));
  endfunction

  // Registered-read regfile; x0 reads as zero and ignores writes.
  logic [31:0] rf_mem [32];
  bit          rf_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
      rf_loaded <= 1'b1;
    end else begin
      if (rf_WE && rf_A3 != 5'd0) rf_mem[rf_A3] <= rf_WD3;
      rf_RD1 <= (rf_A1 == 5'd0) ? 32'd0 : rf_mem[rf_A1];
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus / expectation records
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic        rst;
    logic        v0, we0, l0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1, we1, l1;
    logic [4:0]  a1;
    logic [31:0] d1;
  } stim_t;

  typedef struct packed {
    logic        r0, r1, we;
    logic [4:0]  a1, a3;
    logic [31:0] wd;
    logic        s0, s1;
    logic [31:0] rd;
  } outs_t;

  typedef struct packed {
    stim_t s;
    outs_t e;
  } vec_t;

  function automatic stim_t st(input logic rst_i,
      input logic v0, input logic we0, input logic [4:0] a0,
      input logic [31:0] d0, input logic l0,
      input logic v1, input logic we1, input logic [4:0] a1,
      input logic [31:0] d1, input logic l1);
    stim_t s;
    s.rst = rst_i;
    s.v0 = v0; s.we0 = we0; s.a0 = a0; s.d0 = d0; s.l0 = l0;
    s.v1 = v1; s.we1 = we1; s.a1 = a1; s.d1 = d1; s.l1 = l1;
    return s;
  endfunction

  function automatic outs_t ex(input logic r0, input logic r1,
      input logic we, input logic [4:0] a1, input logic [4:0] a3,
      input logic [31:0] wd, input logic s0, input logic s1,
      input logic [31:0] rd);
    outs_t e;
    e.r0 = r0; e.r1 = r1; e.we = we; e.a1 = a1; e.a3 = a3;
    e.wd = wd; e.s0 = s0; e.s1 = s1; e.rd = rd;
    return e;
  endfunction

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: arbitration rules in plain integers. A lock taken in
  // cycle t is held through cycle t+LOCK_MAX at the latest.
  // -------------------------------------------------------------------------
  int          m_cyc      = 0;
  bit          m_locked   = 1'b0;
  int          m_owner    = 0;
  int          m_prio     = 0;
  int          m_lock_end = 0;
  bit  [1:0]   m_pend     = 2'b00;
  logic [31:0] m_pend_data = 32'd0;
  logic [31:0] m_mem [32];

  outs_t obs;

  // One clock cycle: drive at posedge+1, sample at negedge, advance model.
  task automatic cycle(input stim_t s);
    bit          v  [2];
    bit          we [2];
    bit          lk [2];
    logic [4:0]  ad [2];
    logic [31:0] wd [2];
    int          g;
    logic        e_we;
    logic [4:0]  e_a1, e_a3;
    logic [31:0] e_wd;
    bit   [1:0]  e_rsp;

    rst = s.rst;
    req0_valid = s.v0; req0_we = s.we0; req0_addr = s.a0;
    req0_wdata = s.d0; req0_lock = s.l0;
    req1_valid = s.v1; req1_we = s.we1; req1_addr = s.a1;
    req1_wdata = s.d1; req1_lock = s.l1;

    v[0] = s.v0;  we[0] = s.we0; lk[0] = s.l0; ad[0] = s.a0; wd[0] = s.d0;
    v[1] = s.v1;  we[1] = s.we1; lk[1] = s.l1; ad[1] = s.a1; wd[1] = s.d1;

    @(negedge clk);
    obs = {req0_ready, req1_ready, rf_WE, rf_A1, rf_A3, rf_WD3,
           rsp0_valid, rsp1_valid, rsp_rdata};

    g = -1;
    if (!s.rst) begin
      if (m_locked) begin
        if (v[m_owner]) g = m_owner;
      end else if (v[0] && v[1]) g = m_prio;
      else if (v[0]) g = 0;
      else if (v[1]) g = 1;
    end
    e_we  = (g >= 0) && we[g];
    e_a3  = e_we ? ad[g] : 5'd0;
    e_wd  = e_we ? wd[g] : 32'd0;
    e_a1  = (g >= 0 && !we[g]) ? ad[g] : 5'd0;
    e_rsp = s.rst ? 2'b00 : m_pend;

    check($sformatf("c%0d ready", m_cyc), {obs.r0, obs.r1},
          {(g == 0), (g == 1)});
    check($sformatf("c%0d rf_WE", m_cyc), obs.we, e_we);
    check($sformatf("c%0d rf_A1", m_cyc), obs.a1, e_a1);
    check($sformatf("c%0d rf_A3", m_cyc), obs.a3, e_a3);
    check($sformatf("c%0d rf_WD3", m_cyc), obs.wd, e_wd);
    check($sformatf("c%0d rsp_valid", m_cyc), {obs.s0, obs.s1},
          {e_rsp[0], e_rsp[1]});
    if (s.rst)
      check($sformatf("c%0d rsp_rdata_rst", m_cyc), obs.rd, 32'd0);
    else if (e_rsp != 2'b00)
      check($sformatf("c%0d rsp_rdata", m_cyc), obs.rd, m_pend_data);

    if (s.rst) begin
      m_locked = 1'b0;
      m_owner  = 0;
      m_prio   = 0;
      m_pend   = 2'b00;
    end else begin
      m_pend = 2'b00;
      if (g >= 0) begin
        m_prio = 1 - g;
        if (!we[g]) begin
          m_pend[g]   = 1'b1;
          m_pend_data = (ad[g] == 5'd0) ? 32'd0 : m_mem[ad[g]];
        end else if (ad[g] != 5'd0) begin
          m_mem[ad[g]] = wd[g];
        end
      end
      if (!m_locked) begin
        if (g >= 0 && lk[g]) begin
          m_locked   = 1'b1;
          m_owner    = g;
          m_lock_end = m_cyc + LOCK_MAX;
        end
      end else if (m_cyc == m_lock_end || (g >= 0 && !lk[g])) begin
        m_locked = 1'b0;
      end
    end
    m_cyc++;

    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  vec_t tbl [14];
  stim_t rs;

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = init_val(i);

    // Directed table, starting from reset.
    tbl[0]  = '{st(1, 1,0,5'd3,0,0, 1,0,5'd4,0,0),
                ex(0,0,0,0,0,0,0,0,32'd0)};
    tbl[1]  = '{st(0, 1,0,5'd3,0,0, 1,0,5'd4,0,0),
                ex(1,0,0,5'd3,0,0,0,0,0)};
    tbl[2]  = '{st(0, 1,0,5'd3,0,0, 1,0,5'd4,0,0),
                ex(0,1,0,5'd4,0,0,1,0,32'hA000_0003)};
    tbl[3]  = '{st(0, 0,0,0,0,0, 0,0,0,0,0),
                ex(0,0,0,0,0,0,0,1,32'hA000_0004)};
    tbl[4]  = '{st(0, 1,1,5'd5,32'hDEAD_BEEF,0, 0,0,0,0,0),
                ex(1,0,1,0,5'd5,32'hDEAD_BEEF,0,0,0)};
    tbl[5]  = '{st(0, 0,0,0,0,0, 1,0,5'd5,0,0),
                ex(0,1,0,5'd5,0,0,0,0,0)};
    tbl[6]  = '{st(0, 0,0,0,0,0, 0,0,0,0,0),
                ex(0,0,0,0,0,0,0,1,32'hDEAD_BEEF)};
    tbl[7]  = '{st(0, 1,0,5'd0,0,0, 0,0,0,0,0),
                ex(1,0,0,0,0,0,0,0,0)};
    tbl[8]  = '{st(0, 0,0,0,0,0, 1,1,5'd0,32'h1234_5678,0),
                ex(0,1,1,0,5'd0,32'h1234_5678,1,0,32'd0)};
    tbl[9]  = '{st(0, 1,0,5'd0,0,0, 0,0,0,0,0),
                ex(1,0,0,0,0,0,0,0,0)};
    tbl[10] = '{st(0, 0,0,0,0,0, 0,0,0,0,0),
                ex(0,0,0,0,0,0,1,0,32'd0)};
    tbl[11] = '{st(0, 1,0,5'd7,0,0, 0,0,0,0,0),
                ex(1,0,0,5'd7,0,0,0,0,0)};
    tbl[12] = '{st(1, 1,1,5'd9,32'h55,1, 1,1,5'd9,32'h66,1),
                ex(0,0,0,0,0,0,0,0,32'd0)};
    tbl[13] = '{st(0, 0,0,0,0,0, 0,0,0,0,0),
                ex(0,0,0,0,0,0,0,0,0)};

    rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0;
    req0_wdata = '0;   req0_lock = 1'b0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0;
    req1_wdata = '0;   req1_lock = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].s);
      check($sformatf("t%0d ready", i), {obs.r0, obs.r1},
            {tbl[i].e.r0, tbl[i].e.r1});
      check($sformatf("t%0d rf", i), {obs.we, obs.a1, obs.a3, obs.wd},
            {tbl[i].e.we, tbl[i].e.a1, tbl[i].e.a3, tbl[i].e.wd});
      check($sformatf("t%0d rsp", i), {obs.s0, obs.s1},
            {tbl[i].e.s0, tbl[i].e.s1});
      if (tbl[i].e.s0 || tbl[i].e.s1 || tbl[i].s.rst)
        check($sformatf("t%0d rdata", i), obs.rd, tbl[i].e.rd);
    end

    // Forced release: req1 locks while req0 keeps requesting.
    cycle(st(0, 1,0,5'd1,0,0, 0,0,0,0,0));
    check("lock_pre_r0", obs.r0, 1'b1);
    cycle(st(0, 1,0,5'd2,0,0, 1,1,5'd9,32'h1,1));
    check("lock_take_r1", obs.r1, 1'b1);
    for (int i = 0; i < LOCK_MAX; i++) begin
      cycle(st(0, 1,0,5'd2,0,0, 1,1,5'd9,32'(i),1));
      check($sformatf("lock_hold%0d_r0", i), obs.r0, 1'b0);
      check($sformatf("lock_hold%0d_r1", i), obs.r1, 1'b1);
    end
    cycle(st(0, 1,0,5'd2,0,0, 1,1,5'd9,32'h2,1));
    check("forced_release_r0", {obs.r0, obs.r1}, 2'b10);

    // Lock burst of three writes ending with lock=0.
    cycle(st(0, 0,0,0,0,0, 1,1,5'd10,32'hB0,1));
    check("burst0", {obs.r0, obs.r1}, 2'b01);
    cycle(st(0, 1,0,5'd2,0,0, 1,1,5'd11,32'hB1,1));
    check("burst1", {obs.r0, obs.r1}, 2'b01);
    cycle(st(0, 1,0,5'd2,0,0, 1,1,5'd12,32'hB2,0));
    check("burst2", {obs.r0, obs.r1}, 2'b01);
    cycle(st(0, 1,0,5'd2,0,0, 1,0,5'd13,0,0));
    check("burst_after", {obs.r0, obs.r1}, 2'b10);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rs = st($urandom_range(0, 63) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 3) == 0);
      cycle(rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
